regs: RTL

Architectural integer register file for the RV32I core: 32 x 32-bit registers with x0 hardwired to zero. It serves the two read ports driven by the decode stage and the single write-back port from the execute stage. Same-cycle write-to-read bypass is included, so decode always sees the value being written back. A 4-phase debug access port shares the write path with write-back, and a starvation-hold output guarantees that debug accesses make progress.

---
 rtl/regs.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/regs.sv
// -----------------------------------------------------------------------------
// regs : RV32I architectural integer register file
//
// 32 x 32-bit registers. x0 always reads 0 and ignores writes. Two
// combinational read ports feed decode, and one write port is shared between
// execute-stage write-back and a 4-phase debug access port. Write-back always
// wins the write port; a debug request that is blocked too long raises
// dbg_hold_o so the pipeline can suppress write-back and let debug through.
//
// Parameters
//   STARVE_LIMIT  consecutive blocked debug-request cycles before dbg_hold_o
//                 rises (1..15)
//
// Ports
//   clk          core clock, rising-edge
//   rst          asynchronous active-high reset
//   rs1_raddr_i  read address 1          rs1_rdata_o  read data 1 (comb.)
//   rs2_raddr_i  read address 2          rs2_rdata_o  read data 2 (comb.)
//   rd_waddr_i   write-back address      rd_wdata_i   write-back data
//   reg_wen_i    write-back enable
//   dbg_req_i    debug request (4-phase, held until ack seen)
//   dbg_we_i     debug write (1) / read (0), sampled at grant
//   dbg_addr_i   debug register address, sampled at grant
//   dbg_wdata_i  debug write data, sampled at grant
//   dbg_ack_o    debug acknowledge, one registered cycle per access
//   dbg_rdata_o  pre-access register contents, registered, held until next grant
//   dbg_hold_o   registered request to the pipeline to suppress write-back
// -----------------------------------------------------------------------------
module regs #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_raddr_i,
  input  logic [4:0]  rs2_raddr_i,
  output logic [31:0] rs1_rdata_o,
  output logic [31:0] rs2_rdata_o,
  input  logic [4:0]  rd_waddr_i,
  input  logic [31:0] rd_wdata_i,
  input  logic        reg_wen_i,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_hold_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ACK  = 2'd1,
    D_WAIT = 2'd2
  } dbg_state_e;

  // Register storage; entry 0 is reset to zero and never written.
  logic [31:0] reg_r [32];

  dbg_state_e  state_r;
  dbg_state_e  state_s;
  logic        grant_s;
  logic        wb_act_s;

  logic        wr_en_s;
  logic [4:0]  wr_addr_s;
  logic [31:0] wr_data_s;

  logic [3:0]  starve_r;
  logic [3:0]  starve_s;

  logic        ack_r;
  logic        hold_r;
  logic [31:0] dbg_rdata_r;

  logic [31:0] rs1_s;
  logic [31:0] rs2_s;

  // Read-port value: x0 is zero, an in-flight write-back to the same register
  // is forwarded, otherwise storage.
  function automatic logic [31:0] read_port(
    input logic [4:0]  addr,
    input logic        wb_act,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_data,
    input logic [31:0] stored
  );
    logic [31:0] val;
    if (addr == 5'd0) begin
      val = 32'd0;
    end else if (wb_act && (wb_addr == addr)) begin
      val = wb_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write-back qualifier: writes to x0 are discarded and never count as
  // occupying the write port, so they do not block debug.
  always_comb begin
    wb_act_s = 1'b0;
    if (reg_wen_i && (rd_waddr_i != 5'd0)) begin
      wb_act_s = 1'b1;
    end else begin
      wb_act_s = 1'b0;
    end
  end

  // Combinational read ports with same-cycle bypass.
  always_comb begin
    rs1_s = read_port(rs1_raddr_i, wb_act_s, rd_waddr_i, rd_wdata_i, reg_r[rs1_raddr_i]);
    rs2_s = read_port(rs2_raddr_i, wb_act_s, rd_waddr_i, rd_wdata_i, reg_r[rs2_raddr_i]);
  end

  assign rs1_rdata_o = rs1_s;
  assign rs2_rdata_o = rs2_s;

  // Debug FSM next state; a grant needs an idle FSM and a free write port.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    case (state_r)
      D_IDLE: begin
        if (dbg_req_i && !wb_act_s) begin
          grant_s = 1'b1;
          state_s = D_ACK;
        end else begin
          state_s = D_IDLE;
        end
      end
      D_ACK: begin
        state_s = D_WAIT;
      end
      D_WAIT: begin
        // Requester must drop req before another access can start.
        if (!dbg_req_i) begin
          state_s = D_IDLE;
        end else begin
          state_s = D_WAIT;
        end
      end
      default: begin
        state_s = D_IDLE;
      end
    endcase
  end

  // Debug FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= D_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shared write-port mux: write-back first, debug write only on its grant.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 5'd0;
    wr_data_s = 32'd0;
    if (wb_act_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = rd_waddr_i;
      wr_data_s = rd_wdata_i;
    end else if (grant_s && dbg_we_i && (dbg_addr_i != 5'd0)) begin
      wr_en_s   = 1'b1;
      wr_addr_s = dbg_addr_i;
      wr_data_s = dbg_wdata_i;
    end else begin
      wr_en_s   = 1'b0;
    end
  end

  // Register storage update; reset clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        reg_r[i] <= 32'd0;
      end
    end else if (wr_en_s) begin
      reg_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Starvation count: consecutive idle cycles where a request is blocked by
  // write-back, saturating at the limit; anything else restarts it.
  always_comb begin
    starve_s = 4'd0;
    if ((state_r == D_IDLE) && dbg_req_i && wb_act_s) begin
      if (starve_r >= LIMIT) begin
        starve_s = LIMIT;
      end else begin
        starve_s = starve_r + 4'd1;
      end
    end else begin
      starve_s = 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= 4'd0;
    end else begin
      starve_r <= starve_s;
    end
  end

  // Registered debug outputs. Hold follows the saturated count, so it rises
  // on the edge the limit is reached and falls on the grant edge, where the
  // count clears. Read data is the pre-write contents captured at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r       <= 1'b0;
      hold_r      <= 1'b0;
      dbg_rdata_r <= 32'd0;
    end else begin
      ack_r  <= grant_s;
      hold_r <= (starve_s == LIMIT);
      if (grant_s) begin
        dbg_rdata_r <= (dbg_addr_i == 5'd0) ? 32'd0 : reg_r[dbg_addr_i];
      end
    end
  end

  assign dbg_ack_o   = ack_r;
  assign dbg_hold_o  = hold_r;
  assign dbg_rdata_o = dbg_rdata_r;

  regs_checker u_checker (
    .clk         (clk),
    .rst         (rst),
    .rs1_raddr_i (rs1_raddr_i),
    .rs2_raddr_i (rs2_raddr_i),
    .rs1_rdata_o (rs1_s),
    .rs2_rdata_o (rs2_s),
    .dbg_ack_o   (ack_r),
    .dbg_hold_o  (hold_r)
  );

endmodule

// -----------------------------------------------------------------------------
// regs_checker : protocol and invariant assertions for regs
//
// Ports: observation-only copies of the clock, reset, read ports and the
// debug acknowledge/hold outputs.
// -----------------------------------------------------------------------------
module regs_checker (
  input logic        clk,
  input logic        rst,
  input logic [4:0]  rs1_raddr_i,
  input logic [4:0]  rs2_raddr_i,
  input logic [31:0] rs1_rdata_o,
  input logic [31:0] rs2_rdata_o,
  input logic        dbg_ack_o,
  input logic        dbg_hold_o
);

  // Acknowledge is a single-cycle pulse.
  ack_single_pulse: assert property (@(posedge clk) disable iff (rst)
    dbg_ack_o |=> !dbg_ack_o);

  // Hold is dropped on the grant edge, so it can never coexist with ack.
  ack_no_hold: assert property (@(posedge clk) disable iff (rst)
    dbg_ack_o |-> !dbg_hold_o);

  // x0 always reads zero on both ports.
  x0_rs1_zero: assert property (@(posedge clk) disable iff (rst)
    (rs1_raddr_i == 5'd0) |-> (rs1_rdata_o == 32'd0));

  x0_rs2_zero: assert property (@(posedge clk) disable iff (rst)
    (rs2_raddr_i == 5'd0) |-> (rs2_rdata_o == 32'd0));

endmodule
